uart_core: RTL and testbench

// - Single-clock 8E1 UART: baud tick generator, transmitter and receiver.
// - Frame: start(0), 8 data bits LSB first, even parity, stop(1) = 11 bits.
// - Runtime baud selection. Sits between a byte-wide host and the serial pins.
// - tx_line may be wired to rx_line externally for loopback.

---
 rtl/uart_pkg.sv | 59 +++++
 rtl/uart_baud_gen.sv | 69 ++++++
 rtl/uart_core.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_core.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: baud_sel encoding, divisor lookup, FSM state types
// and frame constants shared by uart_core and uart_baud_gen.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DIV_W      = 16;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int unsigned baud_rate(
    input logic [1:0] sel
  );
    case (sel)
      BAUD_2400:  return 2400;
      BAUD_4800:  return 4800;
      BAUD_9600:  return 9600;
      BAUD_19200: return 19200;
      default:    return 19200;
    endcase
  endfunction

  // Clocks per serial bit (truncating).
  function automatic int unsigned tx_div(
    input int unsigned clk_freq,
    input logic [1:0]  sel
  );
    return clk_freq / baud_rate(sel);
  endfunction

  // Clocks per receiver oversample tick (truncating).
  function automatic int unsigned rx_div(
    input int unsigned clk_freq,
    input int unsigned ovs,
    input logic [1:0]  sel
  );
    return clk_freq / (baud_rate(sel) * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: rx oversample tick and per-bit tx divisor.
// Ports: clk_1, reset, baud_sel_i -> rx_tick_o, baud_chg_o, txdiv_o.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk_1,
  input  logic             reset,
  input  logic [1:0]       baud_sel_i,
  output logic             rx_tick_o,
  output logic             baud_chg_o,
  output logic [DIV_W-1:0] txdiv_o
);

  localparam logic [DIV_W-1:0] TXD0 =
    DIV_W'(tx_div(CLK_FREQ, BAUD_2400));
  localparam logic [DIV_W-1:0] TXD1 =
    DIV_W'(tx_div(CLK_FREQ, BAUD_4800));
  localparam logic [DIV_W-1:0] TXD2 =
    DIV_W'(tx_div(CLK_FREQ, BAUD_9600));
  localparam logic [DIV_W-1:0] TXD3 =
    DIV_W'(tx_div(CLK_FREQ, BAUD_19200));
  localparam logic [DIV_W-1:0] RXD0 =
    DIV_W'(rx_div(CLK_FREQ, OVERSAMPLE, BAUD_2400));
  localparam logic [DIV_W-1:0] RXD1 =
    DIV_W'(rx_div(CLK_FREQ, OVERSAMPLE, BAUD_4800));
  localparam logic [DIV_W-1:0] RXD2 =
    DIV_W'(rx_div(CLK_FREQ, OVERSAMPLE, BAUD_9600));
  localparam logic [DIV_W-1:0] RXD3 =
    DIV_W'(rx_div(CLK_FREQ, OVERSAMPLE, BAUD_19200));

  logic [1:0]       sel_q;
  logic [DIV_W-1:0] rxdiv;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             rx_wrap;

  always_comb begin
    txdiv_o = TXD3;
    rxdiv   = RXD3;
    case (baud_sel_i)
      BAUD_2400:  begin txdiv_o = TXD0; rxdiv = RXD0; end
      BAUD_4800:  begin txdiv_o = TXD1; rxdiv = RXD1; end
      BAUD_9600:  begin txdiv_o = TXD2; rxdiv = RXD2; end
      default:    begin txdiv_o = TXD3; rxdiv = RXD3; end
    endcase
  end

  assign baud_chg_o = (baud_sel_i != sel_q);
  assign rx_wrap    = (rx_cnt_q == rxdiv - DIV_W'(1));
  assign rx_tick_o  = rx_wrap & ~baud_chg_o;

  always_comb begin
    rx_cnt_d = rx_cnt_q + DIV_W'(1);
    if (baud_chg_o || rx_wrap) rx_cnt_d = '0;
  end

  always_ff @(posedge clk_1) begin
    if (reset) begin
      sel_q    <= baud_sel_i;
      rx_cnt_q <= '0;
    end else begin
      sel_q    <= baud_sel_i;
      rx_cnt_q <= rx_cnt_d;
    end
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: 8E1 UART with tx/rx FSMs and runtime baud select.
// Ports: host byte side (data_in, tx_start, out_rx, flags), serial pins.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_1,
  input  logic       reset,
  input  logic [1:0] baud_sel,
  input  logic [7:0] data_in,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_line,
  input  logic       rx_line,
  output logic [7:0] out_rx,
  output logic       rx_valid,
  output logic       error,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic             rx_tick, baud_chg;
  logic [DIV_W-1:0] txdiv;

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk_1      (clk_1),
    .reset      (reset),
    .baud_sel_i (baud_sel),
    .rx_tick_o  (rx_tick),
    .baud_chg_o (baud_chg),
    .txdiv_o    (txdiv)
  );

  tx_state_e        tx_st_q, tx_st_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic             tx_par_q, tx_par_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_end;

  assign tx_end = (tx_cnt_q == txdiv - DIV_W'(1));

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q;
    tx_sh_d   = tx_sh_q;
    tx_idx_d  = tx_idx_q;
    tx_par_d  = tx_par_q;
    tx_line_d = tx_line_q;
    tx_busy_d = tx_busy_q;
    if (tx_st_q != TX_IDLE)
      tx_cnt_d = tx_end ? '0 : tx_cnt_q + DIV_W'(1);
    unique case (tx_st_q)
      TX_IDLE: if (tx_start) begin
        tx_st_d   = TX_START;
        tx_cnt_d  = '0;
        tx_sh_d   = data_in;
        tx_par_d  = ^data_in;
        tx_idx_d  = '0;
        tx_line_d = 1'b0;
        tx_busy_d = 1'b1;
      end
      TX_START: if (tx_end) begin
        tx_st_d   = TX_DATA;
        tx_line_d = tx_sh_q[0];
      end
      TX_DATA: if (tx_end) begin
        if (tx_idx_q == 3'd7) begin
          tx_st_d   = TX_PARITY;
          tx_line_d = tx_par_q;
        end else begin
          tx_sh_d   = tx_sh_q >> 1;
          tx_line_d = tx_sh_q[1];
          tx_idx_d  = tx_idx_q + 3'd1;
        end
      end
      TX_PARITY: if (tx_end) begin
        tx_st_d   = TX_STOP;
        tx_line_d = 1'b1;
      end
      TX_STOP: if (tx_end) begin
        tx_st_d   = TX_IDLE;
        tx_busy_d = 1'b0;
      end
      default: tx_st_d = TX_IDLE;
    endcase
    if (baud_chg) tx_cnt_d = '0;
  end

  logic [1:0]    rx_sync_q;
  logic          rx_s;
  rx_state_e     rx_st_q, rx_st_d;
  logic [TW-1:0] rx_tc_q, rx_tc_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic          rx_par_q, rx_par_d;
  logic          rx_wait_q, rx_wait_d;
  logic [7:0]    out_q, out_d;
  logic          err_q, err_d;
  logic          ferr_q, ferr_d;
  logic          vld_q, vld_d;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_tc_d   = rx_tc_q;
    rx_sh_d   = rx_sh_q;
    rx_idx_d  = rx_idx_q;
    rx_par_d  = rx_par_q;
    rx_wait_d = rx_wait_q;
    out_d     = out_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    vld_d     = 1'b0;
    if (rx_tick) begin
      unique case (rx_st_q)
        // after a framing error, re-arm only once the line is high
        RX_IDLE: begin
          if (rx_wait_q) begin
            if (rx_s) rx_wait_d = 1'b0;
          end else if (!rx_s) begin
            rx_st_d = RX_START;
            rx_tc_d = '0;
          end
        end
        RX_START: begin
          if (rx_tc_q == T_MID) begin
            rx_tc_d  = '0;
            rx_idx_d = '0;
            rx_st_d  = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tc_d = rx_tc_q + TW'(1);
          end
        end
        RX_DATA: begin
          rx_tc_d = rx_tc_q + TW'(1);
          if (rx_tc_q == T_LAST) begin
            rx_tc_d  = '0;
            rx_sh_d  = {rx_s, rx_sh_q[7:1]};
            rx_idx_d = rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_st_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          rx_tc_d = rx_tc_q + TW'(1);
          if (rx_tc_q == T_LAST) begin
            rx_tc_d  = '0;
            rx_par_d = rx_s;
            rx_st_d  = RX_STOP;
          end
        end
        RX_STOP: begin
          rx_tc_d = rx_tc_q + TW'(1);
          if (rx_tc_q == T_LAST) begin
            rx_tc_d   = '0;
            out_d     = rx_sh_q;
            err_d     = (^rx_sh_q) ^ rx_par_q;
            ferr_d    = ~rx_s;
            vld_d     = 1'b1;
            rx_wait_d = ~rx_s;
            rx_st_d   = RX_IDLE;
          end
        end
        default: rx_st_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1) begin
    if (reset) begin
      tx_st_q   <= TX_IDLE;
      tx_cnt_q  <= '0;
      tx_sh_q   <= '0;
      tx_idx_q  <= '0;
      tx_par_q  <= 1'b0;
      tx_line_q <= 1'b1;
      tx_busy_q <= 1'b0;
      rx_sync_q <= 2'b11;
      rx_st_q   <= RX_IDLE;
      rx_tc_q   <= '0;
      rx_sh_q   <= '0;
      rx_idx_q  <= '0;
      rx_par_q  <= 1'b0;
      rx_wait_q <= 1'b0;
      out_q     <= '0;
      err_q     <= 1'b0;
      ferr_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_sh_q   <= tx_sh_d;
      tx_idx_q  <= tx_idx_d;
      tx_par_q  <= tx_par_d;
      tx_line_q <= tx_line_d;
      tx_busy_q <= tx_busy_d;
      rx_sync_q <= {rx_sync_q[0], rx_line};
      rx_st_q   <= rx_st_d;
      rx_tc_q   <= rx_tc_d;
      rx_sh_q   <= rx_sh_d;
      rx_idx_q  <= rx_idx_d;
      rx_par_q  <= rx_par_d;
      rx_wait_q <= rx_wait_d;
      out_q     <= out_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      vld_q     <= vld_d;
    end
  end

  assign tx_line   = tx_line_q;
  assign tx_busy   = tx_busy_q;
  assign out_rx    = out_q;
  assign error     = err_q;
  assign frame_err = ferr_q;
  assign rx_valid  = vld_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core,
// checked against a frame-level model of the 8E1 wire format.
`timescale 1ns/1ps
module tb_uart_core;
  import uart_pkg::*;

  // clock chosen so every baud divides exactly and frames stay short
  localparam int unsigned CLK_FREQ = 3_072_000;
  localparam int unsigned OVS      = 16;

  logic       clk_1    = 1'b0;
  logic       reset    = 1'b1;
  logic [1:0] baud_sel = 2'b11;
  logic [7:0] data_in  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_line, rx_line;
  logic [7:0] out_rx;
  logic       rx_valid, error, frame_err;

  logic loop_en = 1'b1;
  logic rx_drv  = 1'b1;
  assign rx_line = loop_en ? tx_line : rx_drv;

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] rxq[$];
  logic [7:0] exp_out = 8'h00;

  uart_core #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVS)
  ) dut (
    .clk_1     (clk_1),
    .reset     (reset),
    .baud_sel  (baud_sel),
    .data_in   (data_in),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_line   (tx_line),
    .rx_line   (rx_line),
    .out_rx    (out_rx),
    .rx_valid  (rx_valid),
    .error     (error),
    .frame_err (frame_err)
  );

  always #5 clk_1 = ~clk_1;

  always @(negedge clk_1)
    if (rx_valid === 1'b1)
      rxq.push_back({out_rx, error, frame_err});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned bit_clks(input logic [1:0] sel);
    return CLK_FREQ / (2400 * (1 << sel));
  endfunction

  // bit k of the result is the k-th bit on the wire
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_1);
  endtask

  task automatic drive_start(input logic [7:0] d);
    data_in  = d;
    tx_start = 1'b1;
    @(negedge clk_1);
    tx_start = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic check_frame(input logic [10:0] bits,
                             input int unsigned t,
                             input bit poke,
                             input string nm);
    for (int k = 0; k < 11; k++) begin
      int   bad;
      logic got;
      bad = 0;
      got = bits[k];
      for (int c = 0; c < int'(t); c++) begin
        if (tx_line !== bits[k] || tx_busy !== 1'b1) begin
          bad++;
          got = tx_line;
        end
        if (poke && k == 4 && c == 10) begin
          data_in  = ~data_in;
          tx_start = 1'b1;
        end else begin
          tx_start = 1'b0;
        end
        @(negedge clk_1);
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL %s bit%0d: %0d bad cycles, tx_line=%b need %b",
                 nm, k, bad, got, bits[k]);
      end
    end
    vectors++;
    if (tx_busy !== 1'b0 || tx_line !== 1'b1) begin
      miscompares++;
      $display("FAIL %s end: busy=%b line=%b need busy=0 line=1",
               nm, tx_busy, tx_line);
    end
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic pe,
                           input logic fe, input string nm);
    logic [9:0] got;
    int n;
    n = rxq.size();
    got = 'x;
    if (n > 0) got = rxq.pop_front();
    rxq.delete();
    vectors++;
    if (n != 1) begin
      miscompares++;
      $display("FAIL %s pulses: got %0d need 1", nm, n);
    end
    vectors++;
    if (got !== {d, pe, fe}) begin
      miscompares++;
      $display("FAIL %s rx: got %h/%b/%b need %h/%b/%b",
               nm, got[9:2], got[1], got[0], d, pe, fe);
    end
    vectors++;
    if (out_rx !== d || error !== pe || frame_err !== fe) begin
      miscompares++;
      $display("FAIL %s hold: got %h/%b/%b need %h/%b/%b",
               nm, out_rx, error, frame_err, d, pe, fe);
    end
    exp_out = d;
  endtask

  task automatic expect_quiet(input string nm);
    vectors++;
    if (rxq.size() != 0 || out_rx !== exp_out) begin
      miscompares++;
      $display("FAIL %s: pulses=%0d out_rx=%h need 0 and %h",
               nm, rxq.size(), out_rx, exp_out);
    end
    rxq.delete();
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pflip,
                         input logic stopv);
    logic [10:0] bits;
    int unsigned t;
    t = bit_clks(baud_sel);
    bits = frame_of(d);
    bits[9] = bits[9] ^ pflip;
    bits[10] = stopv;
    for (int k = 0; k < 11; k++) begin
      rx_drv = bits[k];
      cycles(int'(t));
    end
    cycles(4);
  endtask

  task automatic test_pkg_div;
    int unsigned txr[4] = '{20833, 10416, 5208, 2604};
    int unsigned rxr[4] = '{1302, 651, 325, 162};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (tx_div(50_000_000, 2'(i)) !== txr[i] ||
          rx_div(50_000_000, 16, 2'(i)) !== rxr[i]) begin
        miscompares++;
        $display("FAIL div sel%0d: got %0d/%0d need %0d/%0d", i,
                 tx_div(50_000_000, 2'(i)),
                 rx_div(50_000_000, 16, 2'(i)), txr[i], rxr[i]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycles(5);
    vectors++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset tx: line=%b busy=%b need 1/0",
               tx_line, tx_busy);
    end
    vectors++;
    if (out_rx !== 8'h00 || rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset rx: out_rx=%h valid=%b need 00/0",
               out_rx, rx_valid);
    end
    vectors++;
    if (error !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset flags: error=%b frame_err=%b need 0/0",
               error, frame_err);
    end
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_loopback_fa;
    logic [10:0] wire_fa;
    wire_fa = 11'b10111110100;
    loop_en = 1'b1;
    drive_start(8'hFA);
    check_frame(wire_fa, bit_clks(2'b11), 1'b0, "fa_tx");
    cycles(4);
    expect_rx(8'hFA, 1'b0, 1'b0, "fa_rx");
  endtask

  task automatic test_parity_err;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    cycles(4);
    send_rx(8'hFA, 1'b1, 1'b1);
    expect_rx(8'hFA, 1'b1, 1'b0, "parity");
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    int unsigned t;
    t = bit_clks(baud_sel);
    send_rx(8'h55, 1'b0, 1'b0);
    expect_rx(8'h55, 1'b0, 1'b1, "frame");
    cycles(12 * int'(t));
    expect_quiet("frame_hold_low");
    rx_drv = 1'b1;
    cycles(2 * int'(t));
    d = 8'($urandom);
    send_rx(d, 1'b0, 1'b1);
    expect_rx(d, 1'b0, 1'b0, "frame_rearm");
  endtask

  task automatic test_glitch;
    int unsigned t;
    t = bit_clks(baud_sel);
    rx_drv = 1'b0;
    cycles(3 * int'(t / OVS));
    rx_drv = 1'b1;
    cycles(3 * int'(t));
    expect_quiet("glitch");
  endtask

  task automatic test_baud00;
    baud_sel = 2'b00;
    loop_en  = 1'b1;
    cycles(4);
    drive_start(8'h3C);
    check_frame(frame_of(8'h3C), bit_clks(2'b00), 1'b1, "b00_tx");
    cycles(4);
    expect_rx(8'h3C, 1'b0, 1'b0, "b00_rx");
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic [1:0] sel;
    for (int i = 0; i < 6; i++) begin
      sel = 2'(2 + $urandom_range(0, 1));
      d   = 8'($urandom);
      baud_sel = sel;
      cycles(4);
      drive_start(d);
      check_frame(frame_of(d), bit_clks(sel), 1'b0, "rnd_tx");
      cycles(4);
      expect_rx(d, 1'b0, 1'b0, "rnd_rx");
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d1, d2;
    int unsigned t;
    baud_sel = 2'b11;
    cycles(4);
    t  = bit_clks(2'b11);
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    drive_start(d1);
    check_frame(frame_of(d1), t, 1'b0, "b2b_tx1");
    expect_rx(d1, 1'b0, 1'b0, "b2b_rx1");
    drive_start(d2);
    check_frame(frame_of(d2), t, 1'b0, "b2b_tx2");
    cycles(4);
    expect_rx(d2, 1'b0, 1'b0, "b2b_rx2");
  endtask

  task automatic test_reset_mid;
    int unsigned t;
    t = bit_clks(2'b11);
    drive_start(8'($urandom));
    cycles(3 * int'(t) + 20);
    reset = 1'b1;
    @(negedge clk_1);
    vectors++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: line=%b busy=%b need 1/0",
               tx_line, tx_busy);
    end
    reset = 1'b0;
    exp_out = 8'h00;
    cycles(12 * int'(t));
    expect_quiet("rst_mid_quiet");
    drive_start(8'hA5);
    check_frame(frame_of(8'hA5), t, 1'b0, "a5_tx");
    cycles(4);
    expect_rx(8'hA5, 1'b0, 1'b0, "a5_rx");
  endtask

  initial begin
    test_pkg_div();
    @(negedge clk_1);
    test_reset();
    test_loopback_fa();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_baud00();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
